alu_req_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/alu_result_mux.sv | 35 +++
 rtl/alu_req_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_req_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings and helpers for the ALU request sequencer.
package alu_seq_pkg;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_RESP  = 2'b11
   } state_t;

   // Responding unit encodings (also REQ_FUNC[3:2])
   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_CMP   = 2'b10;
   localparam logic [1:0] UNIT_SHIFT = 2'b11;

   // Response error codes
   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_TMO  = 2'b01;
   localparam logic [1:0] ERR_FLAG = 2'b10;
   localparam logic [1:0] ERR_DIV0 = 2'b11;

   // Divide opcode, the only one with an operand precondition
   localparam logic [3:0] FUNC_DIV = 4'b0011;

   // Flag vector order: {Shift, CMP, Logic, Arith}; returns the one flag a unit should raise
   function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
      return 4'b0001 << unit;
   endfunction

   // Saturating 16-bit increment for the statistics counters
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/alu_result_mux.sv
// Selects the result of the expected ALU unit, zero-extends it to 32 bits and
// classifies the flag pattern as a clean hit or a mismatch.
module alu_result_mux
   import alu_seq_pkg::*;
(
   input  logic [1:0]  unit,
   input  logic [3:0]  flags,
   input  logic [31:0] arith_out,
   input  logic [15:0] logic_out,
   input  logic [2:0]  cmp_out,
   input  logic [15:0] shift_out,
   output logic        hit,
   output logic        mismatch,
   output logic [31:0] data
);

   logic [3:0] expected;

   // Flag check against the expected unit, then zero-extended unit select
   always_comb begin
      expected = unit_onehot(unit);
      // hit only when the expected flag is the sole flag raised
      hit      = (flags == expected);
      // any foreign flag is an error even if the expected one is also high
      mismatch = |(flags & ~expected);
      data     = 32'd0;
      case (unit)
         UNIT_ARITH: data = arith_out;
         UNIT_LOGIC: data = {16'd0, logic_out};
         UNIT_CMP:   data = {29'd0, cmp_out};
         default:    data = {16'd0, shift_out};
      endcase
   end

endmodule

// File: rtl/alu_req_sequencer.sv
// Initiator-side controller for ALU_TOP: accepts a request, drives the ALU,
// waits for the answering unit's flag, checks it and returns a tagged response.
module alu_req_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DW      = 16,
   parameter int TIMEOUT = 8,
   parameter int TAGW    = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            REQ_VALID,
   output logic            REQ_READY,
   input  logic [DW-1:0]   REQ_A,
   input  logic [DW-1:0]   REQ_B,
   input  logic [3:0]      REQ_FUNC,
   input  logic [TAGW-1:0] REQ_TAG,
   output logic [DW-1:0]   ALU_A,
   output logic [DW-1:0]   ALU_B,
   output logic [3:0]      ALU_FUNC,
   input  logic [31:0]     Arith_OUT,
   input  logic            Carry_OUT,
   input  logic            Arith_Flag,
   input  logic [15:0]     Logic_OUT,
   input  logic            Logic_Flag,
   input  logic [2:0]      CMP_OUT,
   input  logic            CMP_Flag,
   input  logic [15:0]     Shift_OUT,
   input  logic            Shift_Flag,
   output logic            RSP_VALID,
   input  logic            RSP_READY,
   output logic [31:0]     RSP_DATA,
   output logic            RSP_CARRY,
   output logic [1:0]      RSP_UNIT,
   output logic [1:0]      RSP_ERR,
   output logic [TAGW-1:0] RSP_TAG,
   output logic [15:0]     OP_CNT,
   output logic [15:0]     ERR_CNT
);

   localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        accept, div0, rsp_load, rsp_done;
   logic [31:0] rsp_data_d;
   logic        rsp_carry_d;
   logic [1:0]  rsp_unit_d, rsp_err_d;
   logic        hit, mismatch;
   logic [31:0] mux_data;
   logic [1:0]  exp_unit;

   // While waiting, ALU_FUNC still holds the opcode of the request in flight
   assign exp_unit  = ALU_FUNC[3:2];
   assign RSP_VALID = (state_q == ST_RESP);

   alu_result_mux u_mux (
      .unit      (exp_unit),
      .flags     ({Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag}),
      .arith_out (Arith_OUT),
      .logic_out (Logic_OUT),
      .cmp_out   (CMP_OUT),
      .shift_out (Shift_OUT),
      .hit       (hit),
      .mismatch  (mismatch),
      .data      (mux_data)
   );

   // Next-state, wait counter and response load decisions
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      accept      = 1'b0;
      div0        = 1'b0;
      rsp_load    = 1'b0;
      rsp_done    = 1'b0;
      rsp_data_d  = 32'd0;
      rsp_carry_d = 1'b0;
      rsp_unit_d  = exp_unit;
      rsp_err_d   = ERR_OK;
      case (state_q)
         ST_IDLE: begin
            if (REQ_VALID && REQ_READY) begin
               accept = 1'b1;
               if ((REQ_FUNC == FUNC_DIV) && (REQ_B == '0)) begin
                  // Short-circuit: the ALU is never driven with a zero divisor
                  div0       = 1'b1;
                  rsp_load   = 1'b1;
                  rsp_err_d  = ERR_DIV0;
                  rsp_unit_d = UNIT_ARITH;
                  state_d    = ST_RESP;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            cnt_d   = 8'd0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (hit) begin
               rsp_load    = 1'b1;
               rsp_data_d  = mux_data;
               rsp_carry_d = (exp_unit == UNIT_ARITH) && Carry_OUT;
               state_d     = ST_RESP;
            end else if (mismatch) begin
               rsp_load  = 1'b1;
               rsp_err_d = ERR_FLAG;
               state_d   = ST_RESP;
            end else if (cnt_q == TMO_LIM) begin
               rsp_load  = 1'b1;
               rsp_err_d = ERR_TMO;
               state_d   = ST_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RESP: begin
            if (RSP_READY) begin
               rsp_done = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; REQ_READY is registered so it stays low for the first cycle out of reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 8'd0;
         REQ_READY <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         REQ_READY <= (state_d == ST_IDLE);
      end
   end

   // ALU drive, response capture and saturating statistics
   always_ff @(posedge CLK) begin
      if (!RST) begin
         ALU_A     <= '0;
         ALU_B     <= '0;
         ALU_FUNC  <= 4'd0;
         RSP_DATA  <= 32'd0;
         RSP_CARRY <= 1'b0;
         RSP_UNIT  <= 2'd0;
         RSP_ERR   <= 2'd0;
         RSP_TAG   <= '0;
         OP_CNT    <= 16'd0;
         ERR_CNT   <= 16'd0;
      end else begin
         if (accept) begin
            RSP_TAG <= REQ_TAG;
         end
         if (accept && !div0) begin
            ALU_A    <= REQ_A;
            ALU_B    <= REQ_B;
            ALU_FUNC <= REQ_FUNC;
         end
         if (rsp_load) begin
            RSP_DATA  <= rsp_data_d;
            RSP_CARRY <= rsp_carry_d;
            RSP_UNIT  <= rsp_unit_d;
            RSP_ERR   <= rsp_err_d;
         end
         if (rsp_done) begin
            OP_CNT <= sat_inc16(OP_CNT);
            if (RSP_ERR != ERR_OK) begin
               ERR_CNT <= sat_inc16(ERR_CNT);
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Testbench for alu_req_sequencer with a small registered ALU_TOP model.
module tb_alu_req_sequencer;

   localparam int DW      = 16;
   localparam int TIMEOUT = 8;
   localparam int TAGW    = 4;

   logic            CLK = 1'b0;
   logic            RST = 1'b0;
   logic            REQ_VALID, REQ_READY;
   logic [DW-1:0]   REQ_A, REQ_B;
   logic [3:0]      REQ_FUNC;
   logic [TAGW-1:0] REQ_TAG;
   logic [DW-1:0]   ALU_A, ALU_B;
   logic [3:0]      ALU_FUNC;
   logic [31:0]     Arith_OUT;
   logic            Carry_OUT, Arith_Flag;
   logic [15:0]     Logic_OUT;
   logic            Logic_Flag;
   logic [2:0]      CMP_OUT;
   logic            CMP_Flag;
   logic [15:0]     Shift_OUT;
   logic            Shift_Flag;
   logic            RSP_VALID, RSP_READY;
   logic [31:0]     RSP_DATA;
   logic            RSP_CARRY;
   logic [1:0]      RSP_UNIT, RSP_ERR;
   logic [TAGW-1:0] RSP_TAG;
   logic [15:0]     OP_CNT, ERR_CNT;

   int n_checks = 0;
   int n_fail   = 0;
   int alu_mode = 0;   // 0 normal, 1 all flags held low, 2 only Logic_Flag raised

   always #5 CLK = ~CLK;

   alu_req_sequencer #(.DW(DW), .TIMEOUT(TIMEOUT), .TAGW(TAGW)) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_FUNC(REQ_FUNC), .REQ_TAG(REQ_TAG),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUNC(ALU_FUNC),
      .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Arith_Flag(Arith_Flag),
      .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
      .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
      .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
      .RSP_DATA(RSP_DATA), .RSP_CARRY(RSP_CARRY), .RSP_UNIT(RSP_UNIT),
      .RSP_ERR(RSP_ERR), .RSP_TAG(RSP_TAG),
      .OP_CNT(OP_CNT), .ERR_CNT(ERR_CNT)
   );

   function automatic logic add_carry(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16];
   endfunction

   // Registered ALU_TOP model: results and flags one edge after the inputs change
   always @(posedge CLK) begin
      Arith_OUT  <= 32'd0; Carry_OUT <= 1'b0; Arith_Flag <= 1'b0;
      Logic_OUT  <= 16'd0; Logic_Flag <= 1'b0;
      CMP_OUT    <= 3'd0;  CMP_Flag  <= 1'b0;
      Shift_OUT  <= 16'd0; Shift_Flag <= 1'b0;
      if (alu_mode == 2) begin
         Logic_Flag <= 1'b1;
      end else if (alu_mode == 0) begin
         case (ALU_FUNC)
            4'b0000: begin Arith_OUT <= 32'(ALU_A) + 32'(ALU_B); Carry_OUT <= add_carry(ALU_A, ALU_B); end
            4'b0001: Arith_OUT <= 32'(ALU_A) - 32'(ALU_B);
            4'b0010: Arith_OUT <= 32'(ALU_A) * 32'(ALU_B);
            4'b0011: Arith_OUT <= (ALU_B != 16'd0) ? 32'(ALU_A / ALU_B) : 32'd0;
            4'b0100: Logic_OUT <= ALU_A & ALU_B;
            4'b0101: Logic_OUT <= ALU_A | ALU_B;
            4'b0110: Logic_OUT <= ~(ALU_A & ALU_B);
            4'b0111: Logic_OUT <= ~(ALU_A | ALU_B);
            4'b1001: CMP_OUT <= (ALU_A == ALU_B) ? 3'd1 : 3'd0;
            4'b1010: CMP_OUT <= (ALU_A > ALU_B) ? 3'd2 : 3'd0;
            4'b1011: CMP_OUT <= (ALU_A < ALU_B) ? 3'd3 : 3'd0;
            4'b1100: Shift_OUT <= ALU_A >> 1;
            4'b1101: Shift_OUT <= ALU_A << 1;
            4'b1110: Shift_OUT <= ALU_B >> 1;
            4'b1111: Shift_OUT <= ALU_B << 1;
            default: ;
         endcase
         case (ALU_FUNC[3:2])
            2'b00:   Arith_Flag <= 1'b1;
            2'b01:   Logic_Flag <= 1'b1;
            2'b10:   CMP_Flag   <= 1'b1;
            default: Shift_Flag <= 1'b1;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  func;
      logic [3:0]  tag;
      int          mode;
      logic [31:0] data;
      logic [1:0]  unit;
      logic [1:0]  err;
      logic        carry;
      int          lat;    // cycles from the accept edge to the first RSP_VALID cycle
   } vec_t;

   vec_t vecs[10];

   // Issue one request with RSP_READY high, check the response and the handshake
   task automatic run_vec(input vec_t v);
      logic [3:0] func_before;
      logic [3:0] func_exp;
      int  lat;
      bit  seen;
      func_before = ALU_FUNC;
      func_exp    = (v.err == 2'b11) ? func_before : v.func;
      alu_mode    = v.mode;
      @(negedge CLK);
      REQ_A = v.a; REQ_B = v.b; REQ_FUNC = v.func; REQ_TAG = v.tag;
      REQ_VALID = 1'b1; RSP_READY = 1'b1;
      for (int i = 0; i < 20 && !REQ_READY; i++) @(negedge CLK);
      chk("req_ready_before_accept", 32'(REQ_READY), 32'd1);
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         lat++;
         if (RSP_VALID) begin
            seen = 1'b1;
            break;
         end
      end
      chk("rsp_valid_seen", 32'(seen), 32'd1);
      if (seen) begin
         chk("rsp_latency", 32'(lat), 32'(v.lat));
         chk("rsp_data", RSP_DATA, v.data);
         chk("rsp_unit", 32'(RSP_UNIT), 32'(v.unit));
         chk("rsp_err", 32'(RSP_ERR), 32'(v.err));
         chk("rsp_carry", 32'(RSP_CARRY), 32'(v.carry));
         chk("rsp_tag", 32'(RSP_TAG), 32'(v.tag));
         chk("alu_func", 32'(ALU_FUNC), 32'(func_exp));
         @(posedge CLK);
         @(negedge CLK);
         chk("rsp_valid_cleared", 32'(RSP_VALID), 32'd0);
         chk("req_ready_after_rsp", 32'(REQ_READY), 32'd1);
      end
   endtask

   task automatic wait_rsp(input string name, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (RSP_VALID) begin
            seen = 1'b1;
            break;
         end
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int stray;
      REQ_VALID = 1'b0; RSP_READY = 1'b0;
      REQ_A = '0; REQ_B = '0; REQ_FUNC = 4'd0; REQ_TAG = '0;

      // Reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_req_ready", 32'(REQ_READY), 32'd0);
      chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
      chk("rst_alu_a", 32'(ALU_A), 32'd0);
      chk("rst_alu_func", 32'(ALU_FUNC), 32'd0);
      chk("rst_rsp_data", RSP_DATA, 32'd0);
      chk("rst_rsp_tag", 32'(RSP_TAG), 32'd0);
      chk("rst_op_cnt", 32'(OP_CNT), 32'd0);
      chk("rst_err_cnt", 32'(ERR_CNT), 32'd0);
      RST = 1'b1;
      @(negedge CLK);
      chk("ready_after_reset_release", 32'(REQ_READY), 32'd1);

      // a, b, func, tag, mode, data, unit, err, carry, latency
      vecs[0] = '{16'd15,    16'd10,  4'b0000, 4'd5,  0, 32'd25,         2'd0, 2'd0, 1'b0, 3};
      vecs[1] = '{16'd9,     16'd3,   4'b0110, 4'd1,  0, 32'h0000FFFE,   2'd1, 2'd0, 1'b0, 3};
      vecs[2] = '{16'd9,     16'd3,   4'b1101, 4'd2,  0, 32'd18,         2'd3, 2'd0, 1'b0, 3};
      vecs[3] = '{16'hFFFF,  16'd1,   4'b0000, 4'd3,  0, 32'h00010000,   2'd0, 2'd0, 1'b1, 3};
      vecs[4] = '{16'd7,     16'd3,   4'b1010, 4'd4,  0, 32'd2,          2'd2, 2'd0, 1'b0, 3};
      vecs[5] = '{16'd300,   16'd300, 4'b0010, 4'd8,  0, 32'd90000,      2'd0, 2'd0, 1'b0, 3};
      vecs[6] = '{16'd150,   16'd0,   4'b0011, 4'd6,  0, 32'd0,          2'd0, 2'd3, 1'b0, 1};
      vecs[7] = '{16'd1,     16'd2,   4'b0000, 4'd10, 1, 32'd0,          2'd0, 2'd1, 1'b0, TIMEOUT + 3};
      vecs[8] = '{16'd7,     16'd3,   4'b1010, 4'd11, 2, 32'd0,          2'd2, 2'd2, 1'b0, 3};
      vecs[9] = '{16'd100,   16'd7,   4'b0011, 4'd12, 0, 32'd14,         2'd0, 2'd0, 1'b0, 3};

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);
      chk("op_cnt_after_table", 32'(OP_CNT), 32'd10);
      chk("err_cnt_after_table", 32'(ERR_CNT), 32'd3);

      // Backpressure on a flag-mismatch response, with a competing request pending
      alu_mode = 2;
      @(negedge CLK);
      REQ_A = 16'd7; REQ_B = 16'd3; REQ_FUNC = 4'b1010; REQ_TAG = 4'd9;
      REQ_VALID = 1'b1; RSP_READY = 1'b0;
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      wait_rsp("bp_rsp_seen", seen);
      REQ_A = 16'd1; REQ_B = 16'd2; REQ_FUNC = 4'b0000; REQ_TAG = 4'd4;
      REQ_VALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("bp_rsp_valid", 32'(RSP_VALID), 32'd1);
         chk("bp_req_ready", 32'(REQ_READY), 32'd0);
         chk("bp_rsp_err", 32'(RSP_ERR), 32'd2);
         chk("bp_rsp_unit", 32'(RSP_UNIT), 32'd2);
         chk("bp_rsp_data", RSP_DATA, 32'd0);
         chk("bp_rsp_tag", 32'(RSP_TAG), 32'd9);
         chk("bp_alu_func_held", 32'(ALU_FUNC), 32'b1010);
      end
      RSP_READY = 1'b1;
      alu_mode  = 0;
      @(posedge CLK);
      @(negedge CLK);
      chk("bp_rsp_valid_after_hs", 32'(RSP_VALID), 32'd0);
      chk("bp_req_ready_after_hs", 32'(REQ_READY), 32'd1);
      chk("bp_not_accepted_in_resp", 32'(ALU_FUNC), 32'b1010);
      chk("bp_op_cnt", 32'(OP_CNT), 32'd11);
      chk("bp_err_cnt", 32'(ERR_CNT), 32'd4);
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      wait_rsp("bp_next_rsp_seen", seen);
      if (seen) begin
         chk("bp_next_data", RSP_DATA, 32'd3);
         chk("bp_next_tag", 32'(RSP_TAG), 32'd4);
         chk("bp_next_err", 32'(RSP_ERR), 32'd0);
      end
      @(posedge CLK);
      @(negedge CLK);
      chk("bp_op_cnt_final", 32'(OP_CNT), 32'd12);

      // Reset while waiting on the ALU
      @(negedge CLK);
      REQ_A = 16'd15; REQ_B = 16'd10; REQ_FUNC = 4'b0000; REQ_TAG = 4'd7;
      REQ_VALID = 1'b1;
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      @(negedge CLK);   // ISSUE
      @(negedge CLK);   // WAIT
      RST = 1'b0;
      @(negedge CLK);
      chk("wrst_req_ready", 32'(REQ_READY), 32'd0);
      chk("wrst_rsp_valid", 32'(RSP_VALID), 32'd0);
      chk("wrst_alu_a", 32'(ALU_A), 32'd0);
      chk("wrst_alu_b", 32'(ALU_B), 32'd0);
      chk("wrst_alu_func", 32'(ALU_FUNC), 32'd0);
      chk("wrst_rsp_data", RSP_DATA, 32'd0);
      chk("wrst_rsp_err", 32'(RSP_ERR), 32'd0);
      chk("wrst_rsp_tag", 32'(RSP_TAG), 32'd0);
      chk("wrst_op_cnt", 32'(OP_CNT), 32'd0);
      chk("wrst_err_cnt", 32'(ERR_CNT), 32'd0);
      RST = 1'b1;
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (RSP_VALID) stray++;
      end
      chk("wrst_no_response", 32'(stray), 32'd0);
      run_vec(vecs[0]);
      chk("wrst_op_cnt_after_add", 32'(OP_CNT), 32'd1);
      chk("wrst_err_cnt_after_add", 32'(ERR_CNT), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
